// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
// The watchdog register map is for command sequences that drive the on-chip watchdog.
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Watchdog register word offsets (PADDR[11:2])
    localparam logic [9:0] WDOG_LOAD    = 10'h000;
    localparam logic [9:0] WDOG_VALUE   = 10'h001;
    localparam logic [9:0] WDOG_CONTROL = 10'h002;
    localparam logic [9:0] WDOG_INTCLR  = 10'h003;
    localparam logic [9:0] WDOG_RIS     = 10'h004;
    localparam logic [9:0] WDOG_MIS     = 10'h005;
    localparam logic [9:0] WDOG_LOCK    = 10'h300;

    localparam logic [31:0] WDOG_UNLOCK_KEY = 32'h1ACCE551;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which a stalled transfer must abort.
// TIMEOUT = 0 disables the expiry flag entirely.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Wait-state counter; saturates rather than wrapping on a long stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == CNT_LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns single-beat command requests into SETUP/ACCESS transfers
// and returns one response (data, slave error, timeout) per command.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    state_t              state, state_n;
    logic                psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0]   paddr_n;
    logic [DATA_W-1:0]   pwdata_n;
    logic                rsp_valid_n, rsp_err_n, rsp_timeout_n;
    logic [DATA_W-1:0]   rsp_rdata_n;
    logic                wait_expired;

    assign cmd_ready = (state == ST_IDLE);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (state == ST_SETUP),
        .enable  ((state == ST_ACCESS) && !PREADY),
        .expired (wait_expired)
    );

    // State register and registered APB / response outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            PSEL        <= psel_n;
            PENABLE     <= penable_n;
            PWRITE      <= pwrite_n;
            PADDR       <= paddr_n;
            PWDATA      <= pwdata_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition changes it
    always_comb begin
        state_n       = state;
        psel_n        = PSEL;
        penable_n     = PENABLE;
        pwrite_n      = PWRITE;
        paddr_n       = PADDR;
        pwdata_n      = PWDATA;
        rsp_valid_n   = rsp_valid;
        rsp_rdata_n   = rsp_rdata;
        rsp_err_n     = rsp_err;
        rsp_timeout_n = rsp_timeout;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_n   = ST_SETUP;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    pwrite_n  = cmd_write;
                    paddr_n   = cmd_addr;
                    pwdata_n  = cmd_write ? cmd_wdata : '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_n   = ST_ACCESS;
                penable_n = 1'b1;
            end
            ST_ACCESS: begin
                // Completion takes priority over a timeout on the same cycle
                if (PREADY) begin
                    state_n       = ST_RESP;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = PWRITE ? '0 : PRDATA;
                    rsp_err_n     = PSLVERR;
                    rsp_timeout_n = 1'b0;
                end else if (wait_expired) begin
                    state_n       = ST_RESP;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = '0;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                end else begin
                    state_n = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b0;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                psel_n      = 1'b0;
                penable_n   = 1'b0;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

endmodule
